// File: rtl/fft_bfly_sched_pkg.sv
// Shared types and defaults for the radix-2 DIT FFT butterfly sequencer.
// Holds the FSM encoding, default geometry and the drain-counter width helper.
package fft_bfly_sched_pkg;

   localparam int FFT_LOG2_DEF = 6;
   localparam int PIPE_LAT_DEF = 2;
   localparam int STAGE_W      = 3;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   function automatic int cnt_width(input int lat);
      return (lat > 1) ? $clog2(lat) : 1;
   endfunction

endpackage

// File: rtl/fft_bfly_sched_addr_gen.sv
// Combinational butterfly address generator: (stage, butterfly) -> leg addresses and twiddle index.
// Inserting a zero bit at position s of k gives the upper leg; the lower leg is span above it.
module fft_bfly_sched_addr_gen
   import fft_bfly_sched_pkg::*;
#(
   parameter int FFT_LOG2 = FFT_LOG2_DEF
) (
   input  logic [STAGE_W-1:0]  stage_i,
   input  logic [FFT_LOG2-2:0] bfly_i,
   output logic [FFT_LOG2-1:0] addr_a_o,
   output logic [FFT_LOG2-1:0] addr_b_o,
   output logic [FFT_LOG2-2:0] tw_idx_o
);

   logic [FFT_LOG2-1:0] span;
   logic [FFT_LOG2-2:0] mask;
   logic [FFT_LOG2-2:0] pos;
   logic [FFT_LOG2-2:0] grp;

   always_comb begin
      span     = FFT_LOG2'(1) << stage_i;
      mask     = ~({(FFT_LOG2-1){1'b1}} << stage_i);
      pos      = bfly_i & mask;
      grp      = bfly_i >> stage_i;
      addr_a_o = ({1'b0, grp} << (stage_i + STAGE_W'(1))) | {1'b0, pos};
      addr_b_o = addr_a_o + span;
      tw_idx_o = pos << (STAGE_W'(FFT_LOG2 - 1) - stage_i);
   end

endmodule

// File: rtl/fft_bfly_sched.sv
// Stage/butterfly sequencer for the in-place 64-point radix-2 DIT FFT.
// Issues RAM reads and twiddle indices, then replays the addresses as writes PIPE_LAT cycles later.
module fft_bfly_sched
   import fft_bfly_sched_pkg::*;
#(
   parameter int FFT_LOG2 = FFT_LOG2_DEF,
   parameter int PIPE_LAT = PIPE_LAT_DEF
) (
   input  logic                clk,
   input  logic                rstn,
   input  logic                start_i,
   output logic                busy_o,
   output logic                done_o,
   output logic [STAGE_W-1:0]  stage_o,
   output logic                rd_en_o,
   output logic [FFT_LOG2-1:0] rd_addr_a_o,
   output logic [FFT_LOG2-1:0] rd_addr_b_o,
   output logic [FFT_LOG2-2:0] tw_idx_o,
   output logic                wr_en_o,
   output logic [FFT_LOG2-1:0] wr_addr_a_o,
   output logic [FFT_LOG2-1:0] wr_addr_b_o
);

   localparam int K_W   = FFT_LOG2 - 1;
   localparam int CNT_W = cnt_width(PIPE_LAT);
   localparam logic [K_W-1:0]     K_LAST     = {K_W{1'b1}};
   localparam logic [STAGE_W-1:0] S_LAST     = STAGE_W'(FFT_LOG2 - 1);
   localparam logic [CNT_W-1:0]   DRAIN_LAST = CNT_W'(PIPE_LAT - 1);

   state_e              state_q, state_d;
   logic [STAGE_W-1:0]  s_q, s_d;
   logic [K_W-1:0]      k_q, k_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;

   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic [STAGE_W-1:0]  stage_q, stage_d;
   logic                rd_en_q, rd_en_d;
   logic [FFT_LOG2-1:0] rd_a_q, rd_a_d;
   logic [FFT_LOG2-1:0] rd_b_q, rd_b_d;
   logic [K_W-1:0]      tw_q, tw_d;

   logic [PIPE_LAT-1:0] dly_vld_q, dly_vld_d;
   logic [FFT_LOG2-1:0] dly_a_q [PIPE_LAT];
   logic [FFT_LOG2-1:0] dly_a_d [PIPE_LAT];
   logic [FFT_LOG2-1:0] dly_b_q [PIPE_LAT];
   logic [FFT_LOG2-1:0] dly_b_d [PIPE_LAT];

   logic [FFT_LOG2-1:0] gen_a, gen_b;
   logic [K_W-1:0]      gen_tw;

   // Addresses are generated from the next (s,k) so the registered outputs line up with rd_en_o.
   fft_bfly_sched_addr_gen #(
      .FFT_LOG2 (FFT_LOG2)
   ) u_addr_gen (
      .stage_i  (s_d),
      .bfly_i   (k_d),
      .addr_a_o (gen_a),
      .addr_b_o (gen_b),
      .tw_idx_o (gen_tw)
   );

   always_comb begin
      state_d = state_q;
      s_d     = s_q;
      k_d     = k_q;
      cnt_d   = cnt_q;
      rd_en_d = 1'b0;
      done_d  = 1'b0;

      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start_i) begin
               state_d = ST_ISSUE;
               s_d     = '0;
               k_d     = '0;
               rd_en_d = 1'b1;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_ISSUE: begin
            if (k_q == K_LAST) begin
               state_d = ST_DRAIN;
               cnt_d   = '0;
            end else begin
               k_d     = k_q + K_W'(1);
               rd_en_d = 1'b1;
            end
         end
         ST_DRAIN: begin
            // Reads stay off until every write of this stage has landed.
            if (cnt_q == DRAIN_LAST) begin
               if (s_q == S_LAST) begin
                  state_d = ST_DONE;
                  done_d  = 1'b1;
               end else begin
                  state_d = ST_ISSUE;
                  s_d     = s_q + STAGE_W'(1);
                  k_d     = '0;
                  rd_en_d = 1'b1;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase

      busy_d  = (state_d == ST_ISSUE) || (state_d == ST_DRAIN);
      stage_d = busy_d ? s_d : '0;
      rd_a_d  = rd_en_d ? gen_a  : '0;
      rd_b_d  = rd_en_d ? gen_b  : '0;
      tw_d    = rd_en_d ? gen_tw : '0;

      dly_vld_d    = dly_vld_q;
      dly_a_d      = dly_a_q;
      dly_b_d      = dly_b_q;
      dly_vld_d[0] = rd_en_q;
      dly_a_d[0]   = rd_a_q;
      dly_b_d[0]   = rd_b_q;
      for (int i = 1; i < PIPE_LAT; i++) begin
         dly_vld_d[i] = dly_vld_q[i-1];
         dly_a_d[i]   = dly_a_q[i-1];
         dly_b_d[i]   = dly_b_q[i-1];
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q   <= ST_IDLE;
         s_q       <= '0;
         k_q       <= '0;
         cnt_q     <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         stage_q   <= '0;
         rd_en_q   <= 1'b0;
         rd_a_q    <= '0;
         rd_b_q    <= '0;
         tw_q      <= '0;
         dly_vld_q <= '0;
         for (int i = 0; i < PIPE_LAT; i++) begin
            dly_a_q[i] <= '0;
            dly_b_q[i] <= '0;
         end
      end else begin
         state_q   <= state_d;
         s_q       <= s_d;
         k_q       <= k_d;
         cnt_q     <= cnt_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         stage_q   <= stage_d;
         rd_en_q   <= rd_en_d;
         rd_a_q    <= rd_a_d;
         rd_b_q    <= rd_b_d;
         tw_q      <= tw_d;
         dly_vld_q <= dly_vld_d;
         dly_a_q   <= dly_a_d;
         dly_b_q   <= dly_b_d;
      end
   end

   assign busy_o      = busy_q;
   assign done_o      = done_q;
   assign stage_o     = stage_q;
   assign rd_en_o     = rd_en_q;
   assign rd_addr_a_o = rd_a_q;
   assign rd_addr_b_o = rd_b_q;
   assign tw_idx_o    = tw_q;
   assign wr_en_o     = dly_vld_q[PIPE_LAT-1];
   assign wr_addr_a_o = dly_a_q[PIPE_LAT-1];
   assign wr_addr_b_o = dly_b_q[PIPE_LAT-1];

endmodule

// File: tb/tb_fft_bfly_sched.sv
// Directed bench for fft_bfly_sched: default latency instance plus a PIPE_LAT=4 instance on shared inputs.
// Cycle n=1 is the sample taken just after the edge that accepted start_i.
module tb_fft_bfly_sched;

   logic       clk = 1'b0;
   logic       rstn;
   logic       start;

   logic       busy, done, rd_en, wr_en;
   logic [2:0] stage;
   logic [5:0] rd_a, rd_b, wr_a, wr_b;
   logic [4:0] tw;

   logic       busy4, done4, rd_en4, wr_en4;
   logic [2:0] stage4;
   logic [5:0] rd_a4, rd_b4, wr_a4, wr_b4;
   logic [4:0] tw4;

   int n_chk  = 0;
   int n_fail = 0;

   typedef struct packed {
      logic       rd;
      logic [5:0] a;
      logic [5:0] b;
      logic [4:0] tw;
      logic [2:0] stg;
   } exp_t;

   always #5 clk = ~clk;

   fft_bfly_sched #(.FFT_LOG2(6), .PIPE_LAT(2)) u_dut (
      .clk(clk), .rstn(rstn), .start_i(start),
      .busy_o(busy), .done_o(done), .stage_o(stage),
      .rd_en_o(rd_en), .rd_addr_a_o(rd_a), .rd_addr_b_o(rd_b), .tw_idx_o(tw),
      .wr_en_o(wr_en), .wr_addr_a_o(wr_a), .wr_addr_b_o(wr_b)
   );

   fft_bfly_sched #(.FFT_LOG2(6), .PIPE_LAT(4)) u_dut4 (
      .clk(clk), .rstn(rstn), .start_i(start),
      .busy_o(busy4), .done_o(done4), .stage_o(stage4),
      .rd_en_o(rd_en4), .rd_addr_a_o(rd_a4), .rd_addr_b_o(rd_b4), .tw_idx_o(tw4),
      .wr_en_o(wr_en4), .wr_addr_a_o(wr_a4), .wr_addr_b_o(wr_b4)
   );

   task automatic chk(input string tag, input longint obs, input longint exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference schedule: each stage is 32 issue cycles then lat drain cycles.
   function automatic exp_t model(input int lat, input int m);
      exp_t e;
      int   per, s, off, span, a;
      e   = '0;
      per = 32 + lat;
      if (m >= 1 && m <= 6 * per) begin
         s     = (m - 1) / per;
         off   = (m - 1) % per;
         span  = 1 << s;
         e.stg = 3'(s);
         if (off < 32) begin
            a    = (off / span) * 2 * span + off % span;
            e.rd = 1'b1;
            e.a  = 6'(a);
            e.b  = 6'(a + span);
            e.tw = 5'((off % span) * (32 / span));
         end
      end
      return e;
   endfunction

   task automatic check_cycle(input int n, input bit held);
      int   m, m4, tot, tot4;
      exp_t er, ew, er4, ew4;
      tot  = 6 * 34;
      tot4 = 6 * 36;
      m    = held ? ((n - 1) % (tot + 1)) + 1 : n;
      m4   = held ? ((n - 1) % (tot4 + 1)) + 1 : n;
      er   = model(2, m);
      ew   = model(2, m - 2);
      er4  = model(4, m4);
      ew4  = model(4, m4 - 4);

      chk($sformatf("rd_en n=%0d", n), longint'(rd_en), longint'(er.rd));
      if (er.rd) begin
         chk($sformatf("rd_a n=%0d", n), longint'(rd_a), longint'(er.a));
         chk($sformatf("rd_b n=%0d", n), longint'(rd_b), longint'(er.b));
         chk($sformatf("tw n=%0d", n),   longint'(tw),   longint'(er.tw));
      end
      chk($sformatf("wr_en n=%0d", n), longint'(wr_en), longint'(ew.rd));
      if (ew.rd) begin
         chk($sformatf("wr_a n=%0d", n), longint'(wr_a), longint'(ew.a));
         chk($sformatf("wr_b n=%0d", n), longint'(wr_b), longint'(ew.b));
      end
      if (m != tot + 1)
         chk($sformatf("stage n=%0d", n), longint'(stage), longint'(er.stg));
      chk($sformatf("busy n=%0d", n), longint'(busy), longint'(m >= 1 && m <= tot));
      chk($sformatf("done n=%0d", n), longint'(done), longint'(m == tot + 1));

      chk($sformatf("rd_en4 n=%0d", n), longint'(rd_en4), longint'(er4.rd));
      if (er4.rd)
         chk($sformatf("rd_a4 n=%0d", n), longint'(rd_a4), longint'(er4.a));
      chk($sformatf("wr_en4 n=%0d", n), longint'(wr_en4), longint'(ew4.rd));
      if (ew4.rd) begin
         chk($sformatf("wr_a4 n=%0d", n), longint'(wr_a4), longint'(ew4.a));
         chk($sformatf("wr_b4 n=%0d", n), longint'(wr_b4), longint'(ew4.b));
      end
      chk($sformatf("busy4 n=%0d", n), longint'(busy4), longint'(m4 >= 1 && m4 <= tot4));
      chk($sformatf("done4 n=%0d", n), longint'(done4), longint'(m4 == tot4 + 1));
   endtask

   task automatic check_zero(input string pfx);
      chk({pfx, " busy"},  longint'(busy),  0);
      chk({pfx, " done"},  longint'(done),  0);
      chk({pfx, " stage"}, longint'(stage), 0);
      chk({pfx, " rd_en"}, longint'(rd_en), 0);
      chk({pfx, " rd_ab"}, longint'({rd_a, rd_b, tw}), 0);
      chk({pfx, " wr_en"}, longint'(wr_en), 0);
      chk({pfx, " wr_ab"}, longint'({wr_a, wr_b}), 0);
      chk({pfx, " dut4"},  longint'({busy4, done4, stage4, rd_en4, rd_a4, rd_b4, tw4,
                                     wr_en4, wr_a4, wr_b4}), 0);
   endtask

   int   n_rd, n_wr, n_done_a, n_done4_a, hz, bad, act;
   int   wr_hits [6][64];
   logic hv [2];
   logic [5:0] ha [2];
   logic [5:0] hb [2];
   int   ws, dn_b, rn_b;
   logic prev_rd;

   initial begin
      rstn  = 1'b0;
      start = 1'b0;
      repeat (3) step();
      check_zero("por");
      rstn = 1'b1;
      step();
      step();
      check_zero("idle");

      // Run A: single start pulse on both instances.
      n_rd = 0; n_wr = 0; n_done_a = 0; n_done4_a = 0; hz = 0;
      for (int s = 0; s < 6; s++)
         for (int a = 0; a < 64; a++)
            wr_hits[s][a] = 0;
      for (int j = 0; j < 2; j++) begin
         hv[j] = 1'b0; ha[j] = '0; hb[j] = '0;
      end
      start = 1'b1;
      step();
      start = 1'b0;
      for (int n = 1; n <= 230; n++) begin
         check_cycle(n, 1'b0);
         if (rd_en) begin
            n_rd++;
            for (int j = 0; j < 2; j++)
               if (hv[j] && (ha[j] == rd_a || ha[j] == rd_b || hb[j] == rd_a || hb[j] == rd_b))
                  hz++;
         end
         hv[1] = hv[0]; ha[1] = ha[0]; hb[1] = hb[0];
         hv[0] = rd_en; ha[0] = rd_a;  hb[0] = rd_b;
         if (wr_en) begin
            n_wr++;
            ws = (n - 3) / 34;
            if (ws >= 0 && ws < 6) begin
               wr_hits[ws][wr_a]++;
               wr_hits[ws][wr_b]++;
            end
         end
         if (done && n_done_a == 0)  n_done_a  = n;
         if (done4 && n_done4_a == 0) n_done4_a = n;
         if (n == 1) begin
            chk("s0k0 a", longint'(rd_a), 0);
            chk("s0k0 b", longint'(rd_b), 1);
            chk("s0k0 tw", longint'(tw), 0);
         end
         if (n == 32) begin
            chk("s0k31 a", longint'(rd_a), 62);
            chk("s0k31 b", longint'(rd_b), 63);
            chk("s0k31 tw", longint'(tw), 0);
         end
         if (n == 74) begin
            chk("s2k5 a", longint'(rd_a), 9);
            chk("s2k5 b", longint'(rd_b), 13);
            chk("s2k5 tw", longint'(tw), 8);
         end
         if (n == 202) begin
            chk("s5k31 a", longint'(rd_a), 31);
            chk("s5k31 b", longint'(rd_b), 63);
            chk("s5k31 tw", longint'(tw), 31);
         end
         step();
      end
      chk("rd_count", n_rd, 192);
      chk("wr_count", n_wr, 192);
      chk("done_cycle", n_done_a, 205);
      chk("done_cycle_lat4", n_done4_a, 217);
      chk("raw_hazards", hz, 0);
      bad = 0;
      for (int s = 0; s < 6; s++)
         for (int a = 0; a < 64; a++)
            if (wr_hits[s][a] != 1) bad++;
      chk("wr_cover_bad", bad, 0);

      // Run B: start held high across busy and DONE; back-to-back runs.
      dn_b = 0; rn_b = 0; prev_rd = 1'b0;
      start = 1'b1;
      step();
      for (int n = 1; n <= 440; n++) begin
         check_cycle(n, 1'b1);
         if (done && dn_b == 0) dn_b = n;
         if (dn_b != 0 && rn_b == 0 && rd_en && !prev_rd) rn_b = n;
         prev_rd = rd_en;
         step();
      end
      chk("b2b_done", dn_b, 205);
      chk("b2b_gap", rn_b - dn_b, 1);
      start = 1'b0;
      rstn  = 1'b0;
      #1;
      check_zero("abort_b");
      step();
      rstn = 1'b1;
      step();

      // Run C: reset asserted while issuing s=2, k=10.
      start = 1'b1;
      step();
      start = 1'b0;
      for (int n = 1; n <= 79; n++) begin
         check_cycle(n, 1'b0);
         if (n < 79) step();
      end
      chk("s2k10 stage", longint'(stage), 2);
      chk("s2k10 a", longint'(rd_a), 18);
      chk("s2k10 b", longint'(rd_b), 22);
      chk("s2k10 tw", longint'(tw), 16);
      rstn = 1'b0;
      #1;
      check_zero("abort_async");
      step();
      check_zero("abort_held");
      rstn = 1'b1;
      act = 0;
      for (int n = 0; n < 20; n++) begin
         step();
         if (rd_en || wr_en || done || busy || rd_en4 || wr_en4 || done4 || busy4) act++;
      end
      chk("post_abort_activity", act, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
